// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - time-multiplexed BCD 7-segment scanner with frame-synchronous snapshot load
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank zero digits above the most significant nonzero digit)
module bcd_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int GUARD      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   shadow;
  logic [NUM_DIGITS-1:0][3:0]   display;
  logic                         pending;
  logic                         frame_wrap;
  logic                         in_guard;
  logic [NUM_DIGITS-1:0]        onehot;
  logic [NUM_DIGITS-1:0]        blank_mask;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign load_ready = !pending;
  assign frame_wrap = (cnt == LAST_CNT) && (idx == LAST_IDX);
  assign in_guard   = (cnt < GUARD_CNT);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen;
  // A digit is blanked while every digit from the top down to it is zero; digit 0 always shows.
  always_comb begin
    blank_mask = '0;
    seen       = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (display[i] != 4'd0) seen = 1'b1;
      blank_mask[i] = !seen;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      display     <= '0;
      pending     <= 1'b0;
      seg         <= '0;
      an          <= '0;
      frame_start <= 1'b0;
    end else begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Accept needs pending=0 and transfer needs pending=1, so the two never collide.
      if (load_valid && !pending) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end else if (frame_wrap && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end

      an          <= in_guard ? '0 : onehot;
      seg         <= (in_guard || blank_mask[idx]) ? 7'h00 : decode(display[idx]);
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - scoreboard bench for bcd_seg_scanner against a cycle-position reference model
module tb_bcd_seg_scanner;

  localparam int N = 4;
  localparam int P = 4;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [15:0]  digits_in;
  logic         load_ready;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic         frame_start;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_count = 0;

  bcd_seg_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD(G)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .digits_in(digits_in),
    .load_ready(load_ready), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d > 4'd9) ? 7'h40 : tab[d];
  endfunction

  // Reference model: position counts cycles since reset release; slot and phase follow arithmetically.
  initial begin
    int e, pos, slot, ph;
    logic [15:0] m_disp, m_shadow;
    logic m_pend, blank;
    logic [3:0] dig;
    exp_t x;
    e = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        e = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
        q.delete();
      end else begin
        e++;
        pos  = e - 1;
        slot = (pos / P) % N;
        ph   = pos % P;
        dig  = 4'((m_disp >> (4 * slot)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        blank = (slot != 0) && ((m_disp >> (4 * slot)) == 16'd0);
`else
        blank = 1'b0;
`endif
        x.an  = (ph < G) ? 4'b0 : 4'(1 << slot);
        x.seg = (ph < G || blank) ? 7'h00 : seg_of(dig);
        x.fs  = (pos % (N * P)) == 0;
        if (load_valid && !m_pend) begin
          m_shadow = digits_in;
          m_pend   = 1'b1;
          acc_count++;
        end else if (m_pend && (e % (N * P)) == 0) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
        x.rdy = !m_pend;
        q.push_back(x);
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && q.size() > 0) begin
        x = q.pop_front();
        check("an", 32'(an), 32'(x.an));
        check("seg", 32'(seg), 32'(x.seg));
        check("frame_start", 32'(frame_start), 32'(x.fs));
        check("load_ready", 32'(load_ready), 32'(x.rdy));
      end
    end
  end

  task automatic load(input logic [15:0] v);
    int start, n;
    start = acc_count;
    load_valid = 1'b1;
    digits_in  = v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (acc_count == start && n < 200);
    check("load_accept", 32'(acc_count != start), 32'd1);
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1; load_valid = 1'b0; digits_in = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    load(16'h1234);
    idle(41);
    // Asynchronous reset in the middle of a frame must clear outputs immediately.
    #2 reset = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    idle(20);

    load(16'h00F9);
    idle(40);
    load(16'h1111);
    load(16'h2222);
    idle(40);
    load(16'h0050);
    idle(40);
    load(16'h0000);
    idle(40);

    for (int k = 0; k < 40; k++) begin
      v = 16'($urandom);
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 2) == 0) v[4*j +: 4] = 4'h0;
      load(v);
      idle($urandom_range(0, 24));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
